prng_scheduler: RTL and testbench
=================================

# prng_scheduler

Shares one 32-bit Fibonacci LFSR random source between `NREQ` stochastic-computing consumers. A round-robin grant hands each consumer a fresh `OUT_W`-bit random word. The LFSR advances only when a word is consumed or during warm-up, so no word is ever delivered twice. It also owns seeding: it loads a runtime seed, then runs a warm-up phase before serving. It sits between the bitstream generators and the shared random source, replacing free-running per-consumer PRNG instances.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `OUT_W`, 4: delivered word width; equals `$clog2(bs)` for `bs`=16; 1..32.
- `WARMUP`, 32: LFSR steps after reset/reseed before first grant; 0 allowed.

- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_valid`  in  1  load `seed` this cycle.
- `seed`  in  32  new LFSR state.
- `req`  in  `NREQ`  level request per consumer, held until granted.
- `gnt`  out  `NREQ`  one-hot grant pulse, registered.
- `rnd_valid`  out  1  equals `|gnt`.
- `rnd_out`  out  `OUT_W`  random word, valid with `rnd_valid`.
- `busy`  out  1  high in WARM state.

## Operation
- LFSR `q[31:0]`:
  - Feedback is XOR of bits 31,29,28,27,23,20,19,17,15,14,12,11,9,4,3,2.
  - Step is `q <= {q[30:0], fb}`.
  - Reset value is 32'hAAAAAAAA.
- States:
  - WARM: LFSR steps every cycle and `cnt` decrements. When `cnt` is 0, go to SERVE without stepping.
  - SERVE: LFSR steps only on a grant cycle.
- Reset:
  - `q`=AAAAAAAA, `cnt`=`WARMUP`, state = WARM, or SERVE if `WARMUP`=0.
  - Round-robin pointer favours `req[0]`.
  - `gnt`=0, `rnd_valid`=0, `rnd_out`=0, `busy`=(`WARMUP`≠0).
- SERVE with `|req`:
  - Arbiter picks the first asserted requester at or after the pointer, wrapping modulo `NREQ`.
  - Next edge: `gnt` = one-hot of the winner, `rnd_out` = `q[OUT_W-1:0]` (pre-step value), `q` steps, pointer = winner+1 mod `NREQ`.
- No request: `gnt`=0, `rnd_out` holds its last value, `q` holds.
- Seeding:
  - `seed_valid`=1 in any state loads `q` from `seed`. A seed of 0 is replaced by AAAAAAAA, because the all-zero state locks up.
  - On load, `cnt`=`WARMUP` and state = WARM, or SERVE if `WARMUP`=0. No grant is issued that cycle.
- Simultaneous events:
  - `rst` beats `seed_valid`.
  - `seed_valid` beats a pending grant.
  - A grant already on `gnt` this cycle is still valid.
- Requesters:
  - Drop `req` in the cycle `gnt` is seen, or keep it high to queue for the next round.
  - A consumer keeping `req` high gets a grant at most every `NREQ` cycles while others request.
  - A lone requester is granted every cycle.
- Reset mid-WARM or mid-serve: everything returns to reset values on the next edge. Pending requests are serviced afresh from pointer 0.

## Timing
- `req` high in SERVE (cycle n) -> `gnt` and `rnd_out` valid cycle n+1. One-cycle latency, back-to-back throughput 1 word/cycle.
- Reseed at cycle n:
  - `busy` is high at n+1 through n+`WARMUP`.
  - The first grant can appear at cycle n+`WARMUP`+2.
  - The LFSR steps exactly `WARMUP` times before the first delivered word.
- All outputs are registered. No combinational path exists from `req` or `seed` to any output.

## Structure
- Package `prng_pkg`:
  - `LFSR_TAPS` = 32'hB89ADA1C, with feedback = `^(q & LFSR_TAPS)`.
  - `LFSR_RESET` = 32'hAAAAAAAA.
  - State enum {WARM, SERVE}.
- Sub-module `rr_arbiter #(NREQ)`:
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `win` and `win_idx`.
  - Purely combinational.
- The top level holds the LFSR, warm-up counter, pointer, FSM and output registers.

## Test plan
- `WARMUP`=0, reset, `req`=0001 held:
  - First `rnd_out`=4'hA (q=AAAAAAAA).
  - Second `rnd_out`=4'h4 (q=55555554, fb=0).
- `WARMUP`=0, `req`=1111 held:
  - `gnt` sequence 0001,0010,0100,1000,0001, one per cycle.
  - `rnd_out` sequence matches the golden LFSR stepped once per grant.
- `WARMUP`=32:
  - `busy` is high for 32 cycles after reset and no `gnt` appears.
  - First word = golden LFSR after 32 steps from AAAAAAAA, low 4 bits.
- `seed_valid` with `seed`=0, `WARMUP`=0: the following words are identical to the post-reset sequence (AAAAAAAA substitute).
- `seed_valid` asserted in the same cycle as `req`=0100: no grant next cycle. The grant follows on the cycle after, with a word taken from the new seed.
- `rst` asserted mid-WARM and during streaming grants:
  - Next cycle `gnt`=0, `rnd_out`=0, `busy`=1.
  - The sequence restarts exactly as after the initial reset.

Source files
------------

// File: rtl/prng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prng_pkg
//  Description : Shared constants, state encoding and LFSR step function for
//                the shared-PRNG scheduler.
//                  LFSR_TAPS  - feedback mask, fb = ^(q & LFSR_TAPS)
//                  LFSR_RESET - reset / zero-seed substitute state
//                  state_t    - scheduler states {WARM, SERVE}
//                  lfsr_next  - one Fibonacci step, q -> {q[30:0], fb}
//  Revision    : 1.0 - initial release
// ============================================================================
package prng_pkg;

    // Taps at bits 31,29,28,27,23,20,19,17,15,14,12,11,9,4,3,2.
    localparam logic [31:0] LFSR_TAPS  = 32'hB89ADA1C;
    localparam logic [31:0] LFSR_RESET = 32'hAAAAAAAA;

    typedef enum logic [0:0] {
        WARM  = 1'b0,
        SERVE = 1'b1
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {q[30:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin pick. Selects the first
//                asserted request at or after ptr, wrapping modulo NREQ.
//  Ports       : req     [NREQ-1:0]  request vector
//                ptr     [IDX_W-1:0] highest-priority index (< NREQ)
//                en      1           enable; when low no winner is reported
//                win     [NREQ-1:0]  one-hot winner (zero if none)
//                win_idx [IDX_W-1:0] index of winner (zero if none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

    always_comb begin
        logic w_found;
        int   w_j;
        win     = '0;
        win_idx = '0;
        w_found = 1'b0;
        w_j     = 0;
        if (en) begin
            // Scan NREQ slots starting at ptr; the first hit wins.
            for (int k = 0; k < NREQ; k++) begin
                w_j = int'(ptr) + k;
                if (w_j >= NREQ) begin
                    w_j = w_j - NREQ;
                end
                if (!w_found && req[w_j]) begin
                    w_found    = 1'b1;
                    win[w_j]   = 1'b1;
                    win_idx    = IDX_W'(w_j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prng_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : prng_scheduler
//  Description : Shares one 32-bit Fibonacci LFSR among NREQ consumers.
//                Round-robin grants each deliver a fresh OUT_W-bit word; the
//                LFSR only steps on a grant or during warm-up, so no word is
//                ever delivered twice. Handles runtime seeding + warm-up.
//  Ports       : clk        1          clock (posedge)
//                rst        1          synchronous active-high reset
//                seed_valid 1          load seed this cycle
//                seed       32         new LFSR state (0 -> LFSR_RESET)
//                req        NREQ       level requests
//                gnt        NREQ       registered one-hot grant pulse
//                rnd_valid  1          |gnt
//                rnd_out    OUT_W      random word, valid with rnd_valid
//                busy       1          high while warming up
//  Revision    : 1.0 - initial release
// ============================================================================
module prng_scheduler #(
    parameter int NREQ   = 4,
    parameter int OUT_W  = 4,
    parameter int WARMUP = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [31:0]       seed,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic              rnd_valid,
    output logic [OUT_W-1:0]  rnd_out,
    output logic              busy
);
    import prng_pkg::*;

    localparam int c_idx_w = $clog2(NREQ);
    localparam int c_cnt_w = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_init   = c_cnt_w'(WARMUP);
    localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(NREQ - 1);
    // With no warm-up requested the scheduler is ready straight away.
    localparam state_t             c_state_init = (WARMUP == 0) ? SERVE : WARM;

    state_t              r_state,   w_state_nxt;
    logic [31:0]         r_q,       w_q_nxt;
    logic [c_cnt_w-1:0]  r_cnt,     w_cnt_nxt;
    logic [c_idx_w-1:0]  r_ptr,     w_ptr_nxt;
    logic [NREQ-1:0]     r_gnt,     w_gnt_nxt;
    logic                r_rvalid,  w_rvalid_nxt;
    logic [OUT_W-1:0]    r_rnd,     w_rnd_nxt;
    logic                r_busy,    w_busy_nxt;

    logic                w_arb_en;
    logic [NREQ-1:0]     w_win;
    logic [c_idx_w-1:0]  w_win_idx;

    // A seed load pre-empts any grant in the same cycle.
    assign w_arb_en = (r_state == SERVE) && !seed_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .en      (w_arb_en),
        .win     (w_win),
        .win_idx (w_win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_state_init;
            r_q      <= LFSR_RESET;
            r_cnt    <= c_cnt_init;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_rvalid <= 1'b0;
            r_rnd    <= '0;
            r_busy   <= (WARMUP != 0);
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rnd    <= w_rnd_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_rnd_nxt   = r_rnd;

        if (seed_valid) begin
            // All-zero is the LFSR lock-up state; substitute the reset value.
            w_q_nxt     = (seed == 32'h0) ? LFSR_RESET : seed;
            w_cnt_nxt   = c_cnt_init;
            w_state_nxt = c_state_init;
        end else begin
            case (r_state)
                WARM: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = SERVE;
                    end else begin
                        w_q_nxt   = lfsr_next(r_q);
                        w_cnt_nxt = r_cnt - c_cnt_w'(1);
                        // Leave on the last step so the first grant can
                        // follow immediately after the final warm-up step.
                        if (r_cnt == c_cnt_w'(1)) begin
                            w_state_nxt = SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (|w_win) begin
                        w_gnt_nxt = w_win;
                        w_rnd_nxt = r_q[OUT_W-1:0];
                        w_q_nxt   = lfsr_next(r_q);
                        w_ptr_nxt = (w_win_idx == c_last_idx) ? '0
                                                              : w_win_idx + c_idx_w'(1);
                    end
                end
            endcase
        end

        w_rvalid_nxt = |w_gnt_nxt;
        w_busy_nxt   = (w_state_nxt == WARM);
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_rvalid;
    assign rnd_out   = r_rnd;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_prng_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prng_scheduler
//  Description : Self-checking bench. Instance u0 (WARMUP=0) is checked
//                cycle by cycle against a scoreboard fed by a reference LFSR
//                and round-robin model; instance u1 (WARMUP=32) checks
//                warm-up, busy and reset-restart behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prng_scheduler;

    localparam logic [31:0] RST_Q = 32'hAAAAAAAA;

    logic        clk;
    // instance 0 : WARMUP = 0
    logic        rst0, sv0;
    logic [31:0] seed0;
    logic [3:0]  req0, gnt0, rnd_out0;
    logic        rnd_valid0, busy0;
    // instance 1 : WARMUP = 32
    logic        rst1, sv1;
    logic [31:0] seed1;
    logic [3:0]  req1, gnt1, rnd_out1;
    logic        rnd_valid1, busy1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] r;
    } exp_t;
    exp_t        sb[$];

    logic [31:0] m_q;
    int          m_ptr;
    logic [3:0]  m_rnd;
    logic [31:0] g32, g33;

    prng_scheduler #(.NREQ(4), .OUT_W(4), .WARMUP(0)) u0 (
        .clk(clk), .rst(rst0), .seed_valid(sv0), .seed(seed0), .req(req0),
        .gnt(gnt0), .rnd_valid(rnd_valid0), .rnd_out(rnd_out0), .busy(busy0)
    );

    prng_scheduler #(.NREQ(4), .OUT_W(4), .WARMUP(32)) u1 (
        .clk(clk), .rst(rst1), .seed_valid(sv1), .seed(seed1), .req(req1),
        .gnt(gnt1), .rnd_valid(rnd_valid1), .rnd_out(rnd_out1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step written from the explicit tap list.
    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        logic fb;
        fb = q[31] ^ q[29] ^ q[28] ^ q[27] ^ q[23] ^ q[20] ^ q[19] ^ q[17]
           ^ q[15] ^ q[14] ^ q[12] ^ q[11] ^ q[9]  ^ q[4]  ^ q[3]  ^ q[2];
        return {q[30:0], fb};
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset0();
        m_q   = RST_Q;
        m_ptr = 0;
        m_rnd = 4'h0;
        sb.delete();
    endtask

    // One SERVE cycle on u0: predict, push, clock, pop, compare.
    task automatic drive0(input logic [3:0] r);
        exp_t e;
        int   idx;
        req0 = r;
        idx  = pick(r, m_ptr);
        if (idx >= 0) begin
            e.g   = 4'(1 << idx);
            e.r   = m_q[3:0];
            m_rnd = e.r;
            m_q   = lfsr_step(m_q);
            m_ptr = (idx + 1) % 4;
        end else begin
            e.g = 4'h0;
            e.r = m_rnd;
        end
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check("gnt0", gnt0, e.g);
        check("rnd_out0", rnd_out0, e.r);
        check("rnd_valid0", rnd_valid0, |e.g);
    endtask

    // Entered just after a reset edge of u1 with rst1 low and req1 = 1111.
    task automatic warm_then_first(input logic [3:0] exp_word);
        for (int i = 0; i < 31; i++) begin
            tick();
            check("warm_busy", busy1, 1);
            check("warm_nogrant", gnt1, 0);
        end
        tick();
        check("warm_done_busy", busy1, 0);
        check("warm_done_nogrant", gnt1, 0);
        tick();
        check("first_gnt1", gnt1, 4'b0001);
        check("first_word1", rnd_out1, exp_word);
        check("first_valid1", rnd_valid1, 1);
    endtask

    initial begin
        logic [3:0] gexp [5];
        gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        g32 = RST_Q;
        repeat (32) g32 = lfsr_step(g32);
        g33 = lfsr_step(g32);

        rst0 = 1'b1; sv0 = 1'b0; seed0 = 32'h0; req0 = 4'h0;
        rst1 = 1'b1; sv1 = 1'b0; seed1 = 32'h0; req1 = 4'h0;
        tick();
        tick();

        // ---------------- instance 0 : WARMUP = 0 ----------------
        check("rst_gnt0", gnt0, 0);
        check("rst_rnd0", rnd_out0, 0);
        check("rst_valid0", rnd_valid0, 0);
        check("rst_busy0", busy0, 0);
        model_reset0();
        rst0 = 1'b0;

        drive0(4'b0001);
        check("word1_const", rnd_out0, 4'hA);
        drive0(4'b0001);
        check("word2_const", rnd_out0, 4'h4);

        req0 = 4'h0; rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        model_reset0();
        check("rst2_gnt0", gnt0, 0);

        for (int i = 0; i < 5; i++) begin
            drive0(4'b1111);
            check("rr_seq", gnt0, gexp[i]);
        end

        drive0(4'b0101);
        drive0(4'b0000);
        drive0(4'b1000);
        drive0(4'b0110);
        for (int i = 0; i < 12; i++) begin
            drive0(4'($urandom_range(0, 15)));
        end

        // zero seed substitutes the reset state
        sv0 = 1'b1; seed0 = 32'h0; req0 = 4'h0;
        tick();
        check("seed0_nogrant", gnt0, 0);
        m_q = RST_Q;
        sv0 = 1'b0;
        drive0(4'b0010);
        check("seed0_word1", rnd_out0, 4'hA);
        drive0(4'b0010);
        check("seed0_word2", rnd_out0, 4'h4);
        check("lone_gnt", gnt0, 4'b0010);

        // seed beats a pending grant
        sv0 = 1'b1; seed0 = 32'h12345678; req0 = 4'b0100;
        tick();
        check("seedreq_gnt", gnt0, 0);
        check("seedreq_valid", rnd_valid0, 0);
        check("seedreq_hold", rnd_out0, m_rnd);
        m_q = 32'h12345678;
        sv0 = 1'b0;
        drive0(4'b0100);
        check("seedreq_word", rnd_out0, 4'h8);
        check("seedreq_gnt2", gnt0, 4'b0100);

        // reset beats seed
        rst0 = 1'b1; sv0 = 1'b1; seed0 = 32'h0000000F; req0 = 4'h0;
        tick();
        rst0 = 1'b0; sv0 = 1'b0;
        model_reset0();
        drive0(4'b0001);
        check("rst_over_seed", rnd_out0, 4'hA);

        // ---------------- instance 1 : WARMUP = 32 ----------------
        check("u1_rst_busy", busy1, 1);
        check("u1_rst_gnt", gnt1, 0);
        rst1 = 1'b0; req1 = 4'b1111;
        repeat (10) tick();
        check("u1_midwarm_busy", busy1, 1);

        // reset in the middle of warm-up
        rst1 = 1'b1;
        tick();
        check("u1_wrst_gnt", gnt1, 0);
        check("u1_wrst_rnd", rnd_out1, 0);
        check("u1_wrst_busy", busy1, 1);
        rst1 = 1'b0;
        warm_then_first(g32[3:0]);
        tick();
        check("u1_second_gnt", gnt1, 4'b0010);
        check("u1_second_word", rnd_out1, g33[3:0]);

        // reset while streaming
        rst1 = 1'b1;
        tick();
        check("u1_srst_gnt", gnt1, 0);
        check("u1_srst_rnd", rnd_out1, 0);
        check("u1_srst_valid", rnd_valid1, 0);
        check("u1_srst_busy", busy1, 1);
        rst1 = 1'b0;
        warm_then_first(g32[3:0]);

        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
